// File: rtl/mem_access_ctrl_if.sv
// CPU-side request/response bundle for mem_access_ctrl.
interface mem_access_ctrl_if #(
  parameter int ADDR_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_write, req_size,
    output req_signed, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata,
    input  resp_err
  );

  modport slave (
    input  req_valid, req_write, req_size,
    input  req_signed, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata,
    output resp_err
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Load/store controller between the MEM stage and the data RAM port.
// Define MEM_MISALIGN_SPLIT_EN to split misaligned word/half into byte beats.
module mem_access_ctrl #(
  parameter int RD_LAT = 1,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              reset,
  mem_access_ctrl_if.slave  bus,
  output logic              MEMWrite,
  output logic [1:0]        readMode,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] inData,
  input  logic [DATA_W-1:0] outData
);
  typedef enum logic [2:0] {
    IDLE, DRIVE, WAIT, RESP
`ifdef MEM_MISALIGN_SPLIT_EN
    , SPLIT
`endif
  } state_t;

  state_t            state;
  logic [1:0]        lat;
  logic              wr_q;
  logic              sgn_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic              accept;
  logic              illegal;
  logic              misal;
  logic              reject;
  logic              done;

`ifdef MEM_MISALIGN_SPLIT_EN
  logic [1:0]        beat;
  logic [1:0]        last_beat;
  logic [1:0]        beat_nx;
  logic [31:0]       wdata_q;
  logic [31:0]       acc_q;
  logic [31:0]       acc_nx;
  logic [ADDR_W-1:0] nxt_addr;
`endif

  function automatic logic [31:0] ext(
    input logic [31:0] d,
    input logic [1:0]  sz,
    input logic        s
  );
    case (sz)
      2'b01:   ext = {{16{s & d[15]}}, d[15:0]};
      2'b10:   ext = {{24{s & d[7]}}, d[7:0]};
      default: ext = d;
    endcase
  endfunction

  always_comb begin
    accept  = bus.req_valid & bus.req_ready;
    illegal = bus.req_size == 2'b11;
    misal   = (bus.req_size == 2'b00 && bus.req_addr[1:0] != 2'b00)
            | (bus.req_size == 2'b01 && bus.req_addr[0]);
`ifdef MEM_MISALIGN_SPLIT_EN
    reject  = illegal;
`else
    reject  = illegal | misal;
`endif
    done    = wr_q || (int'(lat) >= RD_LAT);
  end

`ifdef MEM_MISALIGN_SPLIT_EN
  always_comb begin
    beat_nx  = beat + 2'd1;
    nxt_addr = addr_q + ADDR_W'(beat_nx);
    acc_nx   = acc_q;
    acc_nx[{beat, 3'b000} +: 8] = outData[7:0];
  end
`endif

  always_ff @(posedge CLK) begin
    if (reset) begin
      state           <= IDLE;
      lat             <= '0;
      wr_q            <= 1'b0;
      sgn_q           <= 1'b0;
      size_q          <= '0;
      addr_q          <= '0;
      bus.req_ready   <= 1'b1;
      bus.resp_valid  <= 1'b0;
      bus.resp_rdata  <= '0;
      bus.resp_err    <= 1'b0;
      MEMWrite        <= 1'b0;
      readMode        <= '0;
      addr            <= '0;
      inData          <= '0;
`ifdef MEM_MISALIGN_SPLIT_EN
      beat            <= '0;
      last_beat       <= '0;
      wdata_q         <= '0;
      acc_q           <= '0;
`endif
    end else begin
      // port and response return to zero unless a branch drives them
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= '0;
      bus.resp_err   <= 1'b0;
      MEMWrite       <= 1'b0;
      readMode       <= '0;
      addr           <= '0;
      inData         <= '0;
      unique case (state)
        IDLE, RESP: begin
          state         <= IDLE;
          bus.req_ready <= 1'b1;
          if (accept) begin
            wr_q          <= bus.req_write;
            size_q        <= bus.req_size;
            sgn_q         <= bus.req_signed;
            addr_q        <= bus.req_addr;
            lat           <= 2'd1;
            bus.req_ready <= 1'b0;
            if (reject) begin
              state          <= RESP;
              bus.resp_valid <= 1'b1;
              bus.resp_err   <= 1'b1;
              bus.req_ready  <= 1'b1;
`ifdef MEM_MISALIGN_SPLIT_EN
            end else if (misal) begin
              state     <= SPLIT;
              wdata_q   <= bus.req_wdata;
              acc_q     <= '0;
              beat      <= '0;
              last_beat <= (bus.req_size == 2'b00) ? 2'd3 : 2'd1;
              MEMWrite  <= bus.req_write;
              readMode  <= 2'b10;
              addr      <= bus.req_addr;
              inData    <= {24'h0, bus.req_wdata[7:0]};
`endif
            end else begin
              state    <= DRIVE;
              MEMWrite <= bus.req_write;
              readMode <= bus.req_size;
              addr     <= bus.req_addr;
              inData   <= bus.req_wdata;
            end
          end
        end
        DRIVE, WAIT: begin
          if (done) begin
            state          <= RESP;
            bus.resp_valid <= 1'b1;
            bus.req_ready  <= 1'b1;
            if (!wr_q)
              bus.resp_rdata <= ext(outData, size_q, sgn_q);
          end else begin
            state    <= WAIT;
            lat      <= lat + 2'd1;
            readMode <= size_q;
            addr     <= addr_q;
          end
        end
`ifdef MEM_MISALIGN_SPLIT_EN
        SPLIT: begin
          if (done) begin
            acc_q <= acc_nx;
            lat   <= 2'd1;
            if (beat == last_beat) begin
              state          <= RESP;
              bus.resp_valid <= 1'b1;
              bus.req_ready  <= 1'b1;
              if (!wr_q)
                bus.resp_rdata <= ext(acc_nx, size_q, sgn_q);
            end else begin
              beat     <= beat_nx;
              MEMWrite <= wr_q;
              readMode <= 2'b10;
              addr     <= nxt_addr;
              inData   <= {24'h0, wdata_q[{beat_nx, 3'b000} +: 8]};
            end
          end else begin
            lat      <= lat + 2'd1;
            readMode <= 2'b10;
            addr     <= addr_q + ADDR_W'(beat);
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed vector bench for mem_access_ctrl with a byte-array RAM model.
module tb_mem_access_ctrl;
  localparam int RD_LAT = 1;

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic        MEMWrite;
  logic [1:0]  readMode;
  logic [7:0]  addr;
  logic [31:0] inData;
  logic [31:0] outData;

  mem_access_ctrl_if #(.ADDR_W(8)) bif ();

  mem_access_ctrl #(
    .RD_LAT(RD_LAT), .ADDR_W(8), .DATA_W(32)
  ) dut (
    .CLK(CLK), .reset(reset), .bus(bif),
    .MEMWrite(MEMWrite), .readMode(readMode),
    .addr(addr), .inData(inData), .outData(outData)
  );

  always #5 CLK = ~CLK;

  logic [7:0] mem [256] = '{default: 8'h00};
  int         wr_cnt = 0;
  int         act_cnt = 0;
  logic [7:0] last_wa = 8'h00;
  logic [7:0] a1, a2, a3;

  assign a1 = addr + 8'd1;
  assign a2 = addr + 8'd2;
  assign a3 = addr + 8'd3;

  always @(posedge CLK) begin
    if (MEMWrite || readMode != 2'b00)
      act_cnt <= act_cnt + 1;
    if (MEMWrite) begin
      wr_cnt  <= wr_cnt + 1;
      last_wa <= addr;
      mem[addr] <= inData[7:0];
      if (readMode != 2'b10) mem[a1] <= inData[15:8];
      if (readMode == 2'b00) begin
        mem[a2] <= inData[23:16];
        mem[a3] <= inData[31:24];
      end
    end
  end

  // junk in the upper bits must be masked by the controller
  always_comb begin
    outData = {mem[a3], mem[a2], mem[a1], mem[addr]};
    if (readMode == 2'b01)
      outData = {16'h5a5a, mem[a1], mem[addr]};
    else if (readMode == 2'b10)
      outData = {24'ha5a5a5, mem[addr]};
  end

  typedef struct {
    logic        wr;
    logic [1:0]  sz;
    logic        sg;
    logic [7:0]  a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          nwr;
    logic [7:0]  wa;
    logic        quiet;
  } vec_t;

  vec_t vt[$];
  int checks = 0;
  int errors = 0;

  function automatic vec_t mk(
    input logic wr, input logic [1:0] sz, input logic sg,
    input logic [7:0] a, input logic [31:0] wd,
    input logic [31:0] rd, input logic er, input int lat,
    input int nwr, input logic [7:0] wa, input logic quiet
  );
    vec_t v;
    v.wr = wr; v.sz = sz; v.sg = sg; v.a = a; v.wd = wd;
    v.rd = rd; v.er = er; v.lat = lat; v.nwr = nwr;
    v.wa = wa; v.quiet = quiet;
    return v;
  endfunction

  task automatic chk(
    input string nm, input logic [31:0] act, input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(
    input logic wr, input logic [1:0] sz, input logic sg,
    input logic [7:0] a, input logic [31:0] wd
  );
    bif.req_valid  = 1'b1;
    bif.req_write  = wr;
    bif.req_size   = sz;
    bif.req_signed = sg;
    bif.req_addr   = a;
    bif.req_wdata  = wd;
  endtask

  task automatic wait_ready(input string nm);
    int n = 0;
    while (!bif.req_ready && n < 20) begin
      @(negedge CLK);
      n++;
    end
    if (!bif.req_ready) begin
      checks++;
      errors++;
      $display("FAIL %s_ready: got 0 expected 1", nm);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int    n;
    int    w0;
    int    c0;
    string nm;
    nm = $sformatf("v%0d", idx);
    @(negedge CLK);
    drive(v.wr, v.sz, v.sg, v.a, v.wd);
    wait_ready(nm);
    w0 = wr_cnt;
    c0 = act_cnt;
    @(negedge CLK);
    bif.req_valid = 1'b0;
    n = 1;
    while (!bif.resp_valid && n < 40) begin
      @(negedge CLK);
      n++;
    end
    chk({nm, "_valid"}, 32'(bif.resp_valid), 32'd1);
    chk({nm, "_lat"}, 32'(n), 32'(v.lat));
    chk({nm, "_rdata"}, bif.resp_rdata, v.rd);
    chk({nm, "_err"}, 32'(bif.resp_err), 32'(v.er));
    chk({nm, "_nwr"}, 32'(wr_cnt - w0), 32'(v.nwr));
    if (v.nwr > 0)
      chk({nm, "_waddr"}, 32'(last_wa), 32'(v.wa));
    if (v.quiet)
      chk({nm, "_quiet"}, 32'(act_cnt - c0), 32'd0);
  endtask

  initial begin
    int pulses;
    bif.req_valid  = 1'b0;
    bif.req_write  = 1'b0;
    bif.req_size   = 2'b00;
    bif.req_signed = 1'b0;
    bif.req_addr   = 8'h00;
    bif.req_wdata  = 32'h0;

    // wr sz sg addr wdata | rdata err lat nwr waddr quiet
    vt.push_back(mk(1, 2'b00, 0, 8'd0, 32'hbbbba00a,
                    32'h0, 0, 2, 1, 8'd0, 0));
    vt.push_back(mk(0, 2'b00, 0, 8'd0, 32'h0,
                    32'hbbbba00a, 0, RD_LAT + 1, 0, 8'd0, 0));
    vt.push_back(mk(0, 2'b10, 1, 8'd0, 32'h0,
                    32'h0000000a, 0, RD_LAT + 1, 0, 8'd0, 0));
    vt.push_back(mk(0, 2'b10, 1, 8'd3, 32'h0,
                    32'hffffffbb, 0, RD_LAT + 1, 0, 8'd0, 0));
    vt.push_back(mk(0, 2'b01, 1, 8'd2, 32'h0,
                    32'hffffbbbb, 0, RD_LAT + 1, 0, 8'd0, 0));
    vt.push_back(mk(0, 2'b01, 0, 8'd2, 32'h0,
                    32'h0000bbbb, 0, RD_LAT + 1, 0, 8'd0, 0));
    vt.push_back(mk(0, 2'b10, 0, 8'd3, 32'h0,
                    32'h000000bb, 0, RD_LAT + 1, 0, 8'd0, 0));
    vt.push_back(mk(1, 2'b10, 0, 8'd4, 32'hdeadbe11,
                    32'h0, 0, 2, 1, 8'd4, 0));
    vt.push_back(mk(0, 2'b00, 0, 8'd4, 32'h0,
                    32'h00000011, 0, RD_LAT + 1, 0, 8'd0, 0));
`ifdef MEM_MISALIGN_SPLIT_EN
    vt.push_back(mk(0, 2'b00, 0, 8'd1, 32'h0,
                    32'h11bbbba0, 0, 4 * RD_LAT + 1, 0, 8'd0, 0));
`else
    vt.push_back(mk(0, 2'b00, 0, 8'd1, 32'h0,
                    32'h0, 1, 1, 0, 8'd0, 1));
`endif
    vt.push_back(mk(1, 2'b11, 0, 8'd8, 32'hffffffff,
                    32'h0, 1, 1, 0, 8'd0, 1));
    vt.push_back(mk(1, 2'b01, 0, 8'd6, 32'hffff5678,
                    32'h0, 0, 2, 1, 8'd6, 0));
    vt.push_back(mk(0, 2'b00, 0, 8'd4, 32'h0,
                    32'h56780011, 0, RD_LAT + 1, 0, 8'd0, 0));
    vt.push_back(mk(0, 2'b01, 1, 8'd6, 32'h0,
                    32'h00005678, 0, RD_LAT + 1, 0, 8'd0, 0));
    vt.push_back(mk(0, 2'b00, 1, 8'd0, 32'h0,
                    32'hbbbba00a, 0, RD_LAT + 1, 0, 8'd0, 0));
`ifdef MEM_MISALIGN_SPLIT_EN
    vt.push_back(mk(1, 2'b01, 0, 8'd255, 32'h00001234,
                    32'h0, 0, 3, 2, 8'd0, 0));
    vt.push_back(mk(0, 2'b01, 0, 8'd255, 32'h0,
                    32'h00001234, 0, 2 * RD_LAT + 1, 0, 8'd0, 0));
`else
    vt.push_back(mk(1, 2'b01, 0, 8'd255, 32'h00001234,
                    32'h0, 1, 1, 0, 8'd0, 1));
    vt.push_back(mk(0, 2'b01, 0, 8'd255, 32'h0,
                    32'h0, 1, 1, 0, 8'd0, 1));
`endif

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_ready", 32'(bif.req_ready), 32'd1);
    chk("rst_valid", 32'(bif.resp_valid), 32'd0);
    chk("rst_rdata", bif.resp_rdata, 32'h0);
    chk("rst_err", 32'(bif.resp_err), 32'd0);
    chk("rst_memwrite", 32'(MEMWrite), 32'd0);
    chk("rst_readmode", 32'(readMode), 32'd0);
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_indata", inData, 32'h0);
    reset = 1'b0;

    foreach (vt[i]) run_vec(i, vt[i]);

`ifdef MEM_MISALIGN_SPLIT_EN
    chk("wrap_mem255", 32'(mem[255]), 32'h34);
    chk("wrap_mem0", 32'(mem[0]), 32'h12);
`else
    chk("wrap_mem255", 32'(mem[255]), 32'h00);
    chk("wrap_mem0", 32'(mem[0]), 32'h0a);
`endif

    // illegal size held back-to-back: second accept on RESP edge
    @(negedge CLK);
    pulses = act_cnt;
    drive(1'b1, 2'b11, 1'b0, 8'd20, 32'h12345678);
    wait_ready("b2b");
    @(negedge CLK);
    chk("b2b_valid1", 32'(bif.resp_valid), 32'd1);
    chk("b2b_err1", 32'(bif.resp_err), 32'd1);
    chk("b2b_ready1", 32'(bif.req_ready), 32'd1);
    @(negedge CLK);
    bif.req_valid = 1'b0;
    chk("b2b_valid2", 32'(bif.resp_valid), 32'd1);
    chk("b2b_err2", 32'(bif.resp_err), 32'd1);
    @(negedge CLK);
    chk("b2b_valid3", 32'(bif.resp_valid), 32'd0);
    chk("b2b_quiet", 32'(act_cnt - pulses), 32'd0);

    // reset in the middle of a store
`ifdef MEM_MISALIGN_SPLIT_EN
    @(negedge CLK);
    drive(1'b1, 2'b00, 1'b0, 8'd9, 32'ha1b2c3d4);
    wait_ready("rst_mid");
    @(negedge CLK);
    bif.req_valid = 1'b0;
    @(negedge CLK);
    chk("mid_beat2_we", 32'(MEMWrite), 32'd1);
    chk("mid_beat2_addr", 32'(addr), 32'd10);
    chk("mid_beat2_data", inData, 32'h000000c3);
    reset = 1'b1;
    @(negedge CLK);
    chk("mid_mem9", 32'(mem[9]), 32'hd4);
    chk("mid_mem11", 32'(mem[11]), 32'h00);
    chk("mid_mem12", 32'(mem[12]), 32'h00);
`else
    @(negedge CLK);
    drive(1'b1, 2'b00, 1'b0, 8'd12, 32'hcafef00d);
    wait_ready("rst_mid");
    @(negedge CLK);
    bif.req_valid = 1'b0;
    chk("mid_we", 32'(MEMWrite), 32'd1);
    chk("mid_addr", 32'(addr), 32'd12);
    reset = 1'b1;
    @(negedge CLK);
`endif
    chk("mid_rst_we", 32'(MEMWrite), 32'd0);
    chk("mid_rst_ready", 32'(bif.req_ready), 32'd1);
    chk("mid_rst_valid", 32'(bif.resp_valid), 32'd0);
    reset = 1'b0;
    pulses = 0;
    repeat (6) begin
      @(negedge CLK);
      if (bif.resp_valid) pulses++;
    end
    chk("mid_no_resp", 32'(pulses), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
